// File: rtl/ppu_vga_scanout.sv
// PPU frame buffer (256x240, 6-bit palette index) scanned out as 2x-doubled VGA with black side borders.
// Optional build macro SCANOUT_SCANLINE_DIM_EN halves RGB on odd scan lines.
module ppu_vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_BORDER = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    input  logic       wr_en,
    input  logic [8:0] wr_row,
    input  logic [8:0] wr_col,
    input  logic [7:0] wr_data,
    input  logic       frame_ready,
    output logic       vga_done,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_LAST_ACT = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST_ACT = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] WIN_L      = 10'(H_BORDER);
    localparam logic [9:0] WIN_R      = 10'(H_ACTIVE - H_BORDER);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        OWN_PPU,
        SCAN
    } own_state_e;

    own_state_e  state, state_nxt;
    logic        ready_latch;

    logic [9:0]  h_cnt, v_cnt;
    logic [9:0]  h_img;
    logic        frame_start, last_active;
    logic        in_win, hs_c, vs_c;
    logic [15:0] rd_addr_c;

    logic        wr_hit;
    logic [15:0] wr_addr;
    logic [5:0]  fb_mem [0:65535];

    logic [15:0] s0_addr;
    logic        s0_win, s0_hs, s0_vs;
    logic        s1_win, s1_hs, s1_vs;
    logic [5:0]  rd_data;
    logic [11:0] pal_rgb, out_rgb;

    logic        unused_bits;

    // ---------------- timing counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_MAX) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        frame_start = pix_ce && (h_cnt == H_MAX) && (v_cnt == V_MAX);
        last_active = pix_ce && (h_cnt == H_LAST_ACT) && (v_cnt == V_LAST_ACT);
        in_win      = (v_cnt < V_ACT) && (h_cnt >= WIN_L) && (h_cnt < WIN_R);
        h_img       = h_cnt - WIN_L;
        rd_addr_c   = {v_cnt[8:1], h_img[8:1]};
        hs_c        = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_c        = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    end

    // ---------------- frame buffer ----------------
    // Rows >= 240 and columns with bit 8 set (PPU's wrapped negative start) are dropped.
    always_comb begin
        wr_hit  = wr_en && (wr_row < 9'd240) && !wr_col[8];
        wr_addr = {wr_row[7:0], wr_col[7:0]};
    end

    // Nonblocking read and write in one process: a same-clk collision returns the old word.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            fb_mem[wr_addr] <= wr_data[5:0];
        end
        if (pix_ce) begin
            rd_data <= fb_mem[s0_addr];
        end
    end

    // ---------------- read pipeline ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_addr <= '0;
            s0_win  <= 1'b0;
            s0_hs   <= 1'b1;
            s0_vs   <= 1'b1;
            s1_win  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
        end else if (pix_ce) begin
            s0_addr <= rd_addr_c;
            s0_win  <= in_win;
            s0_hs   <= hs_c;
            s0_vs   <= vs_c;
            s1_win  <= s0_win;
            s1_hs   <= s0_hs;
            s1_vs   <= s0_vs;
            vga_r   <= s1_win ? out_rgb[11:8] : '0;
            vga_g   <= s1_win ? out_rgb[7:4]  : '0;
            vga_b   <= s1_win ? out_rgb[3:0]  : '0;
            vga_hs  <= s1_hs;
            vga_vs  <= s1_vs;
        end
    end

`ifdef SCANOUT_SCANLINE_DIM_EN
    logic s0_odd, s1_odd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_odd <= 1'b0;
            s1_odd <= 1'b0;
        end else if (pix_ce) begin
            s0_odd <= v_cnt[0];
            s1_odd <= s0_odd;
        end
    end

    always_comb begin
        out_rgb = s1_odd ? {1'b0, pal_rgb[11:9], 1'b0, pal_rgb[7:5], 1'b0, pal_rgb[3:1]} : pal_rgb;
    end
`else
    always_comb begin
        out_rgb = pal_rgb;
    end
`endif

    // ---------------- NES palette ROM ----------------
    always_comb begin
        pal_rgb = 12'h000;
        case (rd_data)
            6'h00: pal_rgb = 12'h666;
            6'h01: pal_rgb = 12'h029;
            6'h02: pal_rgb = 12'h10A;
            6'h03: pal_rgb = 12'h409;
            6'h04: pal_rgb = 12'h607;
            6'h05: pal_rgb = 12'h703;
            6'h06: pal_rgb = 12'h710;
            6'h07: pal_rgb = 12'h520;
            6'h08: pal_rgb = 12'h330;
            6'h09: pal_rgb = 12'h040;
            6'h0A: pal_rgb = 12'h040;
            6'h0B: pal_rgb = 12'h031;
            6'h0C: pal_rgb = 12'h035;
            6'h0D: pal_rgb = 12'h000;
            6'h0E: pal_rgb = 12'h000;
            6'h0F: pal_rgb = 12'h000;
            6'h10: pal_rgb = 12'hAAA;
            6'h11: pal_rgb = 12'h15E;
            6'h12: pal_rgb = 12'h44F;
            6'h13: pal_rgb = 12'h73F;
            6'h14: pal_rgb = 12'hA2C;
            6'h15: pal_rgb = 12'hC26;
            6'h16: pal_rgb = 12'hB21;
            6'h17: pal_rgb = 12'h940;
            6'h18: pal_rgb = 12'h760;
            6'h19: pal_rgb = 12'h380;
            6'h1A: pal_rgb = 12'h180;
            6'h1B: pal_rgb = 12'h073;
            6'h1C: pal_rgb = 12'h078;
            6'h1D: pal_rgb = 12'h000;
            6'h1E: pal_rgb = 12'h000;
            6'h1F: pal_rgb = 12'h000;
            6'h20: pal_rgb = 12'hFFF;
            6'h21: pal_rgb = 12'h6AF;
            6'h22: pal_rgb = 12'h99F;
            6'h23: pal_rgb = 12'hC8F;
            6'h24: pal_rgb = 12'hF7F;
            6'h25: pal_rgb = 12'hF7B;
            6'h26: pal_rgb = 12'hF86;
            6'h27: pal_rgb = 12'hEA3;
            6'h28: pal_rgb = 12'hCB2;
            6'h29: pal_rgb = 12'h8D3;
            6'h2A: pal_rgb = 12'h5E5;
            6'h2B: pal_rgb = 12'h4E9;
            6'h2C: pal_rgb = 12'h4DD;
            6'h2D: pal_rgb = 12'h444;
            6'h2E: pal_rgb = 12'h000;
            6'h2F: pal_rgb = 12'h000;
            6'h30: pal_rgb = 12'hFFF;
            6'h31: pal_rgb = 12'hBDF;
            6'h32: pal_rgb = 12'hCCF;
            6'h33: pal_rgb = 12'hDCF;
            6'h34: pal_rgb = 12'hFCF;
            6'h35: pal_rgb = 12'hFCE;
            6'h36: pal_rgb = 12'hFCC;
            6'h37: pal_rgb = 12'hFDB;
            6'h38: pal_rgb = 12'hEEA;
            6'h39: pal_rgb = 12'hCEA;
            6'h3A: pal_rgb = 12'hBFB;
            6'h3B: pal_rgb = 12'hBFD;
            6'h3C: pal_rgb = 12'hBEF;
            6'h3D: pal_rgb = 12'hAAA;
            6'h3E: pal_rgb = 12'h000;
            6'h3F: pal_rgb = 12'h000;
            default: pal_rgb = 12'h000;
        endcase
    end

    // ---------------- buffer ownership FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OWN_PPU;
        end else begin
            state <= state_nxt;
        end
    end

    // A frame_ready pulse landing on the frame-start cycle itself is honoured immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            OWN_PPU: if (frame_start && (ready_latch || frame_ready)) state_nxt = SCAN;
            SCAN:    if (last_active) state_nxt = OWN_PPU;
            default: state_nxt = OWN_PPU;
        endcase
    end

    always_comb begin
        vga_done = (state == OWN_PPU);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_latch <= 1'b0;
        end else if ((state == OWN_PPU) && frame_start) begin
            ready_latch <= 1'b0;
        end else if (frame_ready) begin
            ready_latch <= 1'b1;
        end
    end

    assign unused_bits = ^{wr_data[7:6], h_img[9], h_img[0], v_cnt[9], v_cnt[0]};

endmodule

// File: doc/ppu_vga_scanout.md
Name: ppu_vga_scanout

Overview:
- Downstream consumer of the PPU render FSM.
- Accepts per-pixel writes (row, col, 8-bit palette index) into an internal 256x240 frame buffer.
- Scans the buffer out as 640x480@60 VGA: 2x pixel doubling, 64-px black side borders, 12-bit RGB via a 64-entry NES palette ROM.
- Drives vga_done, the buffer-ownership handshake that gates PPU rendering.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- H_BORDER, 64, black columns left and right of the 512-px image

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable (25 MHz rate); all scan logic advances only when high
- wr_en  in  1  pixel write strobe from PPU
- wr_row  in  9  write row, valid 0..239
- wr_col  in  9  write column, valid 0..255
- wr_data  in  8  palette index; bits [5:0] used
- frame_ready  in  1  one-clk pulse from PPU: frame fully rendered (PPU vsync)
- vga_done  out  1  1 = PPU owns buffer and may render; 0 = scan of new frame in progress
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: h_cnt=0, v_cnt=0, vga_done=1, vga_hs=1, vga_vs=1, RGB=0, frame_ready latch cleared, pipeline valids cleared. Buffer contents are not cleared.
- Reset mid-frame restarts timing at (0,0) on the next pix_ce after release.

Write port:
- Runs every clk, independent of pix_ce.
- Write occurs when wr_en && wr_row<240 && wr_col[8]==0.
- Address = {wr_row[7:0], wr_col[7:0]}; depth 61440 used of 64K space.
- Writes with row>=240 or col>=256 are dropped silently. This covers the PPU's negative start column, which wraps to 9-bit values >=256.

Timing counters:
- Advance on pix_ce.
- h_cnt counts 0..799 and wraps; v_cnt increments on h wrap, counts 0..524 and wraps.
- hsync low for h_cnt in 656..751.
- vsync low for v_cnt in 490..491.

Read path (3-stage pipeline, each stage advances on pix_ce):
- S0: image window is v<480 && 64<=h<576. Read address = {v[8:1], (h-64)[8:1]}.
- S1: synchronous RAM read data available.
- S2: palette lookup of data[5:0] registers the RGB outputs. Outside the window or in blanking, RGB=0.
- hs/vs are delayed 3 pix_ce to stay aligned with RGB.
- Read/write collision on the same address in the same clk: read returns old data.

Ownership FSM:
- OWN_PPU (vga_done=1):
  - frame_ready pulse sets latch.
  - At frame start (h wraps 799->0 with v wrapping 524->0): if latch is set, go to SCAN and clear latch; otherwise stay and rescan the stale buffer.
- SCAN (vga_done=0):
  - At the last active pixel (v=479, h=639 on pix_ce), go to OWN_PPU.
  - frame_ready during SCAN is latched and consumed at the next frame start.
- frame_ready coincident with frame start in OWN_PPU counts, and SCAN is entered that same transition.
- Scan-out always reads the buffer regardless of state. Tearing is avoided only because the PPU honours vga_done.

Palette ROM:
- 64x12, contents fixed to the team NES palette.
- 0x0F -> 0x000
- 0x30 -> 0xFFF
- 0x16 -> 0xB21

Optional Feature:
- Macro SCANOUT_SCANLINE_DIM_EN.
- Defined: for odd v_cnt, each RGB channel is shifted right 1 bit before the output register (CRT scanline look). Latency is unchanged.
- Undefined: every line is output at full palette value.

Test Plan:
- Reset check: assert rst=0 mid-line -> vga_done=1, hs=vs=1, RGB=0 immediately; after release, first hsync low exactly 656+3 pix_ce later.
- Timing check: free-run one frame with pix_ce every 2nd clk -> 800 pix_ce per line, 525 lines, hsync low 96 pix_ce, vsync low 2 lines.
- Write/readback check: write (row=5, col=10, data=0x30), send frame_ready.
  - Next frame, at v=10/11 and h=84/85, RGB=0xFFF three pix_ce later.
  - Neighbouring pixels holding 0x0F read 0x000.
- Clipping check: write with col=9'h1F9 and row=240 -> no buffer change.
  - Verify address {8'hF0, 8'hF9} region and {row=0, col=0xF9} are unchanged.
- Handshake check, frame_ready delayed:
  - vga_done rises at v=479/h=639.
  - Withhold frame_ready for 2 frames -> vga_done stays 1.
  - Pulse frame_ready -> vga_done falls at the next frame start.
- Handshake check, coincident pulse and dimming:
  - frame_ready pulsed in the exact frame-start cycle -> SCAN entered that cycle.
  - With SCANOUT_SCANLINE_DIM_EN, palette 0x30 on odd v gives 0x777.
